// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for four requesters that drives a 2-to-4 decoder (sel, en_n) and the decoded grant.
// Optional hold limit: define DECODER_RR_ARBITER_TIMEOUT_EN to force-end tenures after MAX_HOLD cycles.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en_n,
    output logic [3:0] gnt_n,
    output logic       busy,
    output logic       timeout
);

    // state | meaning
    // IDLE  | no tenure; arbitrate on any request
    // GRANT | sel owns the bank; en_n low, one gnt_n bit low
    // GAP   | one forced dead cycle after a tenure; pointer advanced
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic              en_n_q, en_n_d;
    logic [3:0]        gnt_n_q, gnt_n_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        win;
    logic [1:0]        idx;
    logic              found;
    logic              hold_expired;

    // Priority scan starting at the pointer, so the previous winner is checked last.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
    assign hold_expired = (cnt_q == HOLD_LAST);
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        en_n_d    = 1'b1;
        gnt_n_d   = 4'hF;
        busy_d    = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = win;
                    en_n_d  = 1'b0;
                    gnt_n_d = ~(4'b0001 << win);
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                busy_d = 1'b1;
                if (!req[sel_q]) begin
                    state_d = GAP;
                    ptr_d   = sel_q + 2'd1;
                end else if (hold_expired) begin
                    state_d   = GAP;
                    ptr_d     = sel_q + 2'd1;
                    timeout_d = 1'b1;
                end else begin
                    en_n_d  = 1'b0;
                    gnt_n_d = gnt_n_q;
                    // Saturate so the counter can never wrap, even with no limit compiled in.
                    cnt_d   = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            en_n_q    <= 1'b1;
            gnt_n_q   <= 4'hF;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            en_n_q    <= en_n_d;
            gnt_n_q   <= gnt_n_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign en_n    = en_n_q;
    assign gnt_n   = gnt_n_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter; the hold-limit scenario runs when DECODER_RR_ARBITER_TIMEOUT_EN is defined.
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic       en_n;
    logic [3:0] gnt_n;
    logic       busy;
    logic       timeout;

    decoder_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sel     (sel),
        .en_n    (en_n),
        .gnt_n   (gnt_n),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       en_n;
        logic [3:0] gnt_n;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected outputs: the decoded grant follows from sel and en_n.
    function automatic exp_t mk(int s, bit e_n, bit b, bit t);
        exp_t       r;
        logic [1:0] sv;
        sv      = 2'(s);
        r.sel   = sv;
        r.en_n  = e_n;
        r.gnt_n = e_n ? 4'hF : ~(4'b0001 << sv);
        r.busy  = b;
        r.to    = t;
        return r;
    endfunction

    task automatic test_reset();
        logic [3:0] rq[$];
        bit         rs[$];
        exp_t       ex[$];
        exp_t       e, o;
        rq = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
        rs = '{1, 1, 0, 0, 0};
        ex = '{mk(0,1,0,0), mk(0,1,0,0), mk(0,0,1,0), mk(0,1,1,0), mk(0,1,0,0)};
        for (int i = 0; i < rq.size(); i++) begin
            rst = rs[i];
            req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = {sel, en_n, gnt_n, busy, timeout};
            n_checks++;
            if (o !== e)
                $display("FAIL reset[%0d]: got sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b, expected sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b",
                         i, o.sel, o.en_n, o.gnt_n, o.busy, o.to, e.sel, e.en_n, e.gnt_n, e.busy, e.to);
            else
                n_pass++;
        end
    endtask

    task automatic test_single();
        logic [3:0] rq[$];
        exp_t       ex[$];
        exp_t       e, o;
        rq = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
        ex = '{mk(2,0,1,0), mk(2,0,1,0), mk(2,0,1,0), mk(2,1,1,0), mk(2,1,0,0)};
        for (int i = 0; i < rq.size(); i++) begin
            req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = {sel, en_n, gnt_n, busy, timeout};
            n_checks++;
            if (o !== e)
                $display("FAIL single[%0d]: got sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b, expected sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b",
                         i, o.sel, o.en_n, o.gnt_n, o.busy, o.to, e.sel, e.en_n, e.gnt_n, e.busy, e.to);
            else
                n_pass++;
        end
    endtask

    // Pointer is 3 here: requester 3 beats 0, then 0 wins while 3 still asks.
    task automatic test_wrap();
        logic [3:0] rq[$];
        exp_t       ex[$];
        exp_t       e, o;
        rq = '{4'h9, 4'h9, 4'h1, 4'h9, 4'h9, 4'h8, 4'h0};
        ex = '{mk(3,0,1,0), mk(3,0,1,0), mk(3,1,1,0), mk(3,1,0,0),
               mk(0,0,1,0), mk(0,1,1,0), mk(0,1,0,0)};
        for (int i = 0; i < rq.size(); i++) begin
            req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = {sel, en_n, gnt_n, busy, timeout};
            n_checks++;
            if (o !== e)
                $display("FAIL wrap[%0d]: got sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b, expected sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b",
                         i, o.sel, o.en_n, o.gnt_n, o.busy, o.to, e.sel, e.en_n, e.gnt_n, e.busy, e.to);
            else
                n_pass++;
        end
    endtask

    // Pointer is 1 before the reset; req 1001 afterwards picks 0 only if the pointer restarted.
    task automatic test_reset_mid_grant();
        logic [3:0] rq[$];
        bit         rs[$];
        exp_t       ex[$];
        exp_t       e, o;
        rq = '{4'h8, 4'h8, 4'h8, 4'h9, 4'h8, 4'h0};
        rs = '{0, 0, 1, 0, 0, 0};
        ex = '{mk(3,0,1,0), mk(3,0,1,0), mk(0,1,0,0), mk(0,0,1,0), mk(0,1,1,0), mk(0,1,0,0)};
        for (int i = 0; i < rq.size(); i++) begin
            rst = rs[i];
            req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = {sel, en_n, gnt_n, busy, timeout};
            n_checks++;
            if (o !== e)
                $display("FAIL reset_mid_grant[%0d]: got sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b, expected sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b",
                         i, o.sel, o.en_n, o.gnt_n, o.busy, o.to, e.sel, e.en_n, e.gnt_n, e.busy, e.to);
            else
                n_pass++;
        end
    endtask

    task automatic test_fairness();
        logic [3:0] rq[$];
        bit         rs[$];
        exp_t       ex[$];
        exp_t       e, o;
        int         wseq[5] = '{0, 1, 2, 3, 0};
        rq.push_back(4'h0); rs.push_back(1); ex.push_back(mk(0,1,0,0));
        foreach (wseq[j]) begin
            rq.push_back(4'hF); rs.push_back(0); ex.push_back(mk(wseq[j],0,1,0));
            rq.push_back(4'hF); rs.push_back(0); ex.push_back(mk(wseq[j],0,1,0));
            rq.push_back(4'hF & ~(4'b0001 << wseq[j])); rs.push_back(0); ex.push_back(mk(wseq[j],1,1,0));
            rq.push_back(4'hF); rs.push_back(0); ex.push_back(mk(wseq[j],1,0,0));
        end
        for (int i = 0; i < rq.size(); i++) begin
            rst = rs[i];
            req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = {sel, en_n, gnt_n, busy, timeout};
            n_checks++;
            if (o !== e)
                $display("FAIL fairness[%0d]: got sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b, expected sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b",
                         i, o.sel, o.en_n, o.gnt_n, o.busy, o.to, e.sel, e.en_n, e.gnt_n, e.busy, e.to);
            else
                n_pass++;
        end
        req = 4'h0;
    endtask

`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
    // MAX_HOLD = 4: forced exit with timeout, then a release on the limit cycle itself.
    task automatic test_timeout();
        logic [3:0] rq[$];
        exp_t       ex[$];
        exp_t       e, o;
        for (int i = 0; i < 4; i++) begin rq.push_back(4'h2); ex.push_back(mk(1,0,1,0)); end
        rq.push_back(4'h2); ex.push_back(mk(1,1,1,1));
        rq.push_back(4'h2); ex.push_back(mk(1,1,0,0));
        for (int i = 0; i < 4; i++) begin rq.push_back(4'h2); ex.push_back(mk(1,0,1,0)); end
        rq.push_back(4'h0); ex.push_back(mk(1,1,1,0));
        rq.push_back(4'h0); ex.push_back(mk(1,1,0,0));
        for (int i = 0; i < rq.size(); i++) begin
            req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = {sel, en_n, gnt_n, busy, timeout};
            n_checks++;
            if (o !== e)
                $display("FAIL timeout[%0d]: got sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b, expected sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b",
                         i, o.sel, o.en_n, o.gnt_n, o.busy, o.to, e.sel, e.en_n, e.gnt_n, e.busy, e.to);
            else
                n_pass++;
        end
    endtask
`else
    // Without the limit a held request keeps the grant well past MAX_HOLD cycles.
    task automatic test_no_limit();
        logic [3:0] rq[$];
        exp_t       ex[$];
        exp_t       e, o;
        for (int i = 0; i < 12; i++) begin rq.push_back(4'h2); ex.push_back(mk(1,0,1,0)); end
        rq.push_back(4'h0); ex.push_back(mk(1,1,1,0));
        rq.push_back(4'h0); ex.push_back(mk(1,1,0,0));
        for (int i = 0; i < rq.size(); i++) begin
            req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = {sel, en_n, gnt_n, busy, timeout};
            n_checks++;
            if (o !== e)
                $display("FAIL no_limit[%0d]: got sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b, expected sel=%0d en_n=%b gnt_n=%h busy=%b timeout=%b",
                         i, o.sel, o.en_n, o.gnt_n, o.busy, o.to, e.sel, e.en_n, e.gnt_n, e.busy, e.to);
            else
                n_pass++;
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 4'hF;
        test_reset();
        test_single();
        test_wrap();
        test_reset_mid_grant();
        test_fairness();
`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_no_limit();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
